// File: rtl/fwd_hazard_unit_pkg.sv
// Shared forwarding definitions: operand-source encodings and default widths
// used across the pipeline.
package fwd_hazard_unit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RADDR_DEF = 5;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_MC    = 2'b11
  } fwd_sel_e;

  // Clamp a latency into the countdown range; values outside 2..15 saturate.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    if (lat > 15) begin
      return 4'd15;
    end else if (lat < 2) begin
      return 4'd2;
    end else begin
      return CNT_W'(lat);
    end
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-operand forwarding mux: picks the youngest matching producer for one
// ID/EX source register, with the multi-cycle writeback taking precedence.
module fwd_port_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF
) (
  input  logic [RADDR-1:0] rs,
  input  logic [XLEN-1:0]  rs_data,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic             exmem_wen,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic             memwb_wen,
  input  logic [XLEN-1:0]  memwb_result,
  input  logic             mc_wb_valid,
  input  logic [RADDR-1:0] mc_wb_rd,
  input  logic [XLEN-1:0]  mc_wb_result,
  output logic [1:0]       decision,
  output logic [XLEN-1:0]  data
);

  localparam logic [RADDR-1:0] ZERO_ADDR = {RADDR{1'b0}};

  fwd_sel_e sel_s;

  // Source priority; r0 is hard-wired and never forwarded.
  always_comb begin
    sel_s = FWD_RF;
    if (rs == ZERO_ADDR) begin
      sel_s = FWD_RF;
    end else if (mc_wb_valid && (mc_wb_rd == rs)) begin
      sel_s = FWD_MC;
    end else if (exmem_wen && (exmem_rd == rs)) begin
      sel_s = FWD_EXMEM;
    end else if (memwb_wen && (memwb_rd == rs)) begin
      sel_s = FWD_MEMWB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  // Operand data steered by the chosen source.
  always_comb begin
    data = rs_data;
    case (sel_s)
      FWD_RF:    data = rs_data;
      FWD_EXMEM: data = exmem_result;
      FWD_MEMWB: data = memwb_result;
      FWD_MC:    data = mc_wb_result;
      default:   data = rs_data;
    endcase
  end

  assign decision = sel_s;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard detection: per-port bypass muxes, load-use
// stall, and a per-register scoreboard for the multi-cycle unit.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NPORTS = 2,
  parameter int RADDR  = RADDR_DEF,
  parameter int MC_LAT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORTS*RADDR-1:0] idex_rs,
  input  logic [NPORTS*XLEN-1:0]  idex_rs_data,
  input  logic [RADDR-1:0]        exmem_rd,
  input  logic                    exmem_wen,
  input  logic                    exmem_is_load,
  input  logic [XLEN-1:0]         exmem_result,
  input  logic [RADDR-1:0]        memwb_rd,
  input  logic                    memwb_wen,
  input  logic [XLEN-1:0]         memwb_result,
  input  logic                    mc_issue,
  input  logic [RADDR-1:0]        mc_rd,
  input  logic                    mc_wb_valid,
  input  logic [RADDR-1:0]        mc_wb_rd,
  input  logic [XLEN-1:0]         mc_wb_result,
  output logic [NPORTS*2-1:0]     forward_decision,
  output logic [NPORTS*XLEN-1:0]  forward_data,
  output logic                    stall,
  output logic                    mc_busy
);

  localparam int                NREGS     = 2 ** RADDR;
  localparam logic [CNT_W-1:0]  MC_LAT_C  = lat_to_cnt(MC_LAT);
  localparam logic [RADDR-1:0]  ZERO_ADDR = {RADDR{1'b0}};

  logic [NREGS-1:0]            pending_r;
  logic [NREGS-1:0][CNT_W-1:0] count_r;
  logic [RADDR-1:0]            rs_s;
  logic                        load_use_s;
  logic                        pend_stall_s;
  logic                        issue_ok_s;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    fwd_port_sel #(
      .XLEN  (XLEN),
      .RADDR (RADDR)
    ) u_sel (
      .rs           (idex_rs[p*RADDR +: RADDR]),
      .rs_data      (idex_rs_data[p*XLEN +: XLEN]),
      .exmem_rd     (exmem_rd),
      .exmem_wen    (exmem_wen),
      .exmem_result (exmem_result),
      .memwb_rd     (memwb_rd),
      .memwb_wen    (memwb_wen),
      .memwb_result (memwb_result),
      .mc_wb_valid  (mc_wb_valid),
      .mc_wb_rd     (mc_wb_rd),
      .mc_wb_result (mc_wb_result),
      .decision     (forward_decision[p*2 +: 2]),
      .data         (forward_data[p*XLEN +: XLEN])
    );
  end

  // Hazard detection; a pending register being written back this cycle is
  // satisfied by the bypass rather than stalled on.
  always_comb begin
    rs_s         = ZERO_ADDR;
    load_use_s   = 1'b0;
    pend_stall_s = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      rs_s         = idex_rs[p*RADDR +: RADDR];
      load_use_s   = load_use_s | ((rs_s != ZERO_ADDR) & exmem_is_load & exmem_wen
                                   & (exmem_rd == rs_s));
      pend_stall_s = pend_stall_s | ((rs_s != ZERO_ADDR) & pending_r[rs_s]
                                     & ~(mc_wb_valid & (mc_wb_rd == rs_s)));
    end
  end

  assign stall      = load_use_s | pend_stall_s;
  assign issue_ok_s = mc_issue & ~stall & (mc_rd != ZERO_ADDR);
  assign mc_busy    = |pending_r;

  // Scoreboard: issue (re)arms, writeback clears, countdown saturates at 0.
  // Issue wins over a same-cycle writeback to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {NREGS{1'b0}};
      count_r   <= {(NREGS*CNT_W){1'b0}};
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (issue_ok_s && (mc_rd == RADDR'(r))) begin
          pending_r[r] <= 1'b1;
          count_r[r]   <= MC_LAT_C;
        end else if (mc_wb_valid && (mc_wb_rd == RADDR'(r))) begin
          pending_r[r] <= 1'b0;
          count_r[r]   <= {CNT_W{1'b0}};
        end else if (count_r[r] != {CNT_W{1'b0}}) begin
          count_r[r]   <= count_r[r] - 4'd1;
        end else begin
          count_r[r]   <= count_r[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: expectations queued as stimulus is
// applied, then drained and compared once outputs have settled.
module tb_fwd_hazard_unit;

  localparam int XLEN = 32;
  localparam int NP   = 2;
  localparam int RA   = 5;

  typedef enum int {K_DEC0, K_DEC1, K_DATA0, K_DATA1, K_STALL, K_BUSY, K_CNT} kind_e;
  typedef struct {
    kind_e       kind;
    string       tag;
    logic [31:0] exp;
    int          idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [RA-1:0]   rs0, rs1;
  logic [XLEN-1:0] rd0, rd1;
  logic [RA-1:0]   exmem_rd, memwb_rd, mc_rd, mc_wb_rd;
  logic            exmem_wen, exmem_is_load, memwb_wen, mc_issue, mc_wb_valid;
  logic [XLEN-1:0] exmem_result, memwb_result, mc_wb_result;
  logic [NP*2-1:0]    forward_decision;
  logic [NP*XLEN-1:0] forward_data;
  logic               stall, mc_busy;
  logic [NP*RA-1:0]   idex_rs;
  logic [NP*XLEN-1:0] idex_rs_data;

  assign idex_rs      = {rs1, rs0};
  assign idex_rs_data = {rd1, rd0};

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(XLEN), .NPORTS(NP), .RADDR(RA), .MC_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_rs(idex_rs), .idex_rs_data(idex_rs_data),
    .exmem_rd(exmem_rd), .exmem_wen(exmem_wen), .exmem_is_load(exmem_is_load),
    .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_wen(memwb_wen), .memwb_result(memwb_result),
    .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_wb_valid(mc_wb_valid),
    .mc_wb_rd(mc_wb_rd), .mc_wb_result(mc_wb_result),
    .forward_decision(forward_decision), .forward_data(forward_data),
    .stall(stall), .mc_busy(mc_busy)
  );

  function automatic logic [31:0] observe(kind_e k, int idx);
    case (k)
      K_DEC0:  return {30'd0, forward_decision[1:0]};
      K_DEC1:  return {30'd0, forward_decision[3:2]};
      K_DATA0: return forward_data[31:0];
      K_DATA1: return forward_data[63:32];
      K_STALL: return {31'd0, stall};
      K_BUSY:  return {31'd0, mc_busy};
      K_CNT:   return {28'd0, dut.count_r[idx]};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(kind_e k, string tag, logic [31:0] v, int idx = 0);
    exp_t e;
    e.kind = k; e.tag = tag; e.exp = v; e.idx = idx;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.kind, e.idx);
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs0 = 5'd0; rs1 = 5'd0;
    rd0 = 32'hA0A0_0000; rd1 = 32'hB1B1_0001;
    exmem_rd = 5'd0; exmem_wen = 1'b0; exmem_is_load = 1'b0; exmem_result = 32'hE0E0_1111;
    memwb_rd = 5'd0; memwb_wen = 1'b0; memwb_result = 32'hD0D0_2222;
    mc_issue = 1'b0; mc_rd = 5'd0; mc_wb_valid = 1'b0; mc_wb_rd = 5'd0;
    mc_wb_result = 32'hC0C0_3333;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    push(K_BUSY, "rst_busy", 32'd0);
    push(K_STALL, "rst_stall", 32'd0);
    push(K_DEC0, "rst_dec0", 32'd0);
    push(K_DATA0, "rst_data0", 32'hA0A0_0000);
    check();
    tick();
    rst_n = 1'b1;

    // EX/MEM beats MEM/WB on the same address
    rs0 = 5'd5; exmem_rd = 5'd5; exmem_wen = 1'b1; memwb_rd = 5'd5; memwb_wen = 1'b1;
    push(K_DEC0, "exmem_pri_dec", 32'd2);
    push(K_DATA0, "exmem_pri_data", 32'hE0E0_1111);
    push(K_DEC1, "p1_rf_dec", 32'd0);
    push(K_DATA1, "p1_rf_data", 32'hB1B1_0001);
    check();
    exmem_wen = 1'b0;
    push(K_DEC0, "memwb_dec", 32'd1);
    push(K_DATA0, "memwb_data", 32'hD0D0_2222);
    check();
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd5; exmem_wen = 1'b1;
    push(K_DEC0, "mc_pri_dec", 32'd3);
    push(K_DATA0, "mc_pri_data", 32'hC0C0_3333);
    push(K_STALL, "mc_pri_stall", 32'd0);
    check();
    tick();

    // r0 never forwards
    idle();
    rs0 = 5'd0; exmem_rd = 5'd0; exmem_wen = 1'b1;
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd0;
    push(K_DEC0, "r0_dec", 32'd0);
    push(K_DATA0, "r0_data", 32'hA0A0_0000);
    check();
    idle();
    rs0 = 5'd6; exmem_rd = 5'd6; exmem_wen = 1'b0;
    push(K_DEC0, "no_wen_dec", 32'd0);
    check();
    tick();

    // load-use then resolved through MEM/WB
    idle();
    rs1 = 5'd7; exmem_rd = 5'd7; exmem_wen = 1'b1; exmem_is_load = 1'b1;
    mc_issue = 1'b1; mc_rd = 5'd12;
    push(K_STALL, "load_use_stall", 32'd1);
    push(K_DEC1, "load_use_dec1", 32'd2);
    check();
    tick();
    push(K_BUSY, "issue_during_stall", 32'd0);
    check();
    idle();
    rs1 = 5'd7; memwb_rd = 5'd7; memwb_wen = 1'b1;
    push(K_STALL, "after_load_stall", 32'd0);
    push(K_DEC1, "after_load_dec1", 32'd1);
    push(K_DATA1, "after_load_data1", 32'hD0D0_2222);
    check();
    tick();

    // multi-cycle issue, countdown, writeback bypass
    idle();
    rs0 = 5'd9; mc_issue = 1'b1; mc_rd = 5'd9;
    push(K_STALL, "mc_issue_stall", 32'd0);
    check();
    tick();
    mc_issue = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      push(K_STALL, $sformatf("mc_wait_stall_c%0d", c), 32'd1);
      push(K_BUSY, $sformatf("mc_wait_busy_c%0d", c), 32'd1);
      push(K_CNT, $sformatf("mc_wait_cnt_c%0d", c), 32'(5 - c), 9);
      check();
      tick();
    end
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd9;
    push(K_STALL, "mc_wb_stall", 32'd0);
    push(K_DEC0, "mc_wb_dec0", 32'd3);
    push(K_DATA0, "mc_wb_data0", 32'hC0C0_3333);
    check();
    tick();
    mc_wb_valid = 1'b0;
    push(K_BUSY, "mc_wb_busy_clr", 32'd0);
    push(K_DEC0, "mc_wb_dec0_after", 32'd0);
    push(K_STALL, "mc_wb_stall_after", 32'd0);
    check();

    // countdown saturates at zero and keeps stalling on port 1
    idle();
    mc_issue = 1'b1; mc_rd = 5'd10;
    tick();
    mc_issue = 1'b0; rs1 = 5'd10;
    repeat (6) tick();
    push(K_CNT, "sat_cnt", 32'd0, 10);
    push(K_STALL, "sat_stall", 32'd1);
    push(K_BUSY, "sat_busy", 32'd1);
    check();
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd10;
    tick();
    idle();
    push(K_BUSY, "sat_clr_busy", 32'd0);
    check();

    // asynchronous reset mid-countdown
    mc_issue = 1'b1; mc_rd = 5'd9;
    tick();
    mc_issue = 1'b0; rs0 = 5'd9;
    tick();
    push(K_BUSY, "pre_rst_busy", 32'd1);
    push(K_STALL, "pre_rst_stall", 32'd1);
    check();
    #1 rst_n = 1'b0;
    push(K_BUSY, "async_rst_busy", 32'd0);
    push(K_STALL, "async_rst_stall", 32'd0);
    check();
    tick();
    rst_n = 1'b1;
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd9;
    push(K_DEC0, "post_rst_wb_dec", 32'd3);
    check();
    tick();
    mc_wb_valid = 1'b0;
    push(K_BUSY, "post_rst_wb_busy", 32'd0);
    check();

    // issue and writeback to the same register in one cycle
    idle();
    mc_issue = 1'b1; mc_rd = 5'd3; mc_wb_valid = 1'b1; mc_wb_rd = 5'd3;
    tick();
    idle();
    rs0 = 5'd3;
    push(K_BUSY, "same_cyc_busy", 32'd1);
    push(K_CNT, "same_cyc_cnt", 32'd4, 3);
    push(K_STALL, "same_cyc_stall", 32'd1);
    check();
    mc_wb_valid = 1'b1; mc_wb_rd = 5'd3;
    tick();
    idle();

    // WAW reissue reloads the countdown
    mc_issue = 1'b1; mc_rd = 5'd11;
    tick();
    mc_issue = 1'b0;
    tick();
    push(K_CNT, "waw_mid_cnt", 32'd3, 11);
    check();
    mc_issue = 1'b1; mc_rd = 5'd11;
    tick();
    mc_issue = 1'b0;
    push(K_CNT, "waw_reload_cnt", 32'd4, 11);
    push(K_BUSY, "waw_busy", 32'd1);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
